// File: rtl/uart_rx_stream_if.sv
// Byte stream port of uart_rx_stream: valid/ready handshake carrying one byte.
// The master side (receiver) drives data/valid; the slave side (consumer) drives ready.
interface uart_rx_stream_if;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in;

  modport master (output data_out, output valid_out, input ready_in);
  modport slave  (input data_out, input valid_out, output ready_in);
endinterface

// File: rtl/uart_rx_stream.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a
// one-entry holding register presented on a valid/ready stream port.
module uart_rx_stream #(
  parameter int unsigned CLOCK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE     = 115200
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              uart_rxd_in,
  uart_rx_stream_if.master  stream,
  output logic              framing_error_out,
  output logic              overrun_out,
  output logic              parity_error_out
);
  localparam int unsigned BIT_PERIOD  = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
  localparam int unsigned CNT_W       = $clog2(BIT_PERIOD) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_sync;
  logic [1:0]         r_warm;
  logic               r_rxd_prev;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic [7:0]         r_data;
  logic               r_valid;
`ifdef UART_RX_PARITY_EN
  logic               r_par;
  logic               w_par_en;
  logic               w_par_err;
`endif

  logic w_rxd_s, w_fall, w_tick;
  logic w_load_half, w_load_bit, w_shift_en;
  logic w_byte_done, w_frame_err;

  assign w_rxd_s = r_sync[1];
  // r_rxd_prev only goes high once a real line sample has passed the
  // synchronizer, so a line held low out of reset never looks like an edge.
  assign w_fall  = r_rxd_prev & ~w_rxd_s;
  assign w_tick  = (r_cnt == '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load_half = 1'b0;
    w_load_bit  = 1'b0;
    w_shift_en  = 1'b0;
    w_byte_done = 1'b0;
    w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_en    = 1'b0;
    w_par_err   = 1'b0;
`endif
    case (r_state)
      S_IDLE: if (w_fall) begin
        w_next      = S_START;
        w_load_half = 1'b1;
      end
      S_START: if (w_tick) begin
        if (w_rxd_s) w_next = S_IDLE;
        else begin
          w_next     = S_DATA;
          w_load_bit = 1'b1;
        end
      end
      S_DATA: if (w_tick) begin
        w_shift_en = 1'b1;
        w_load_bit = 1'b1;
        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_tick) begin
        w_par_en   = 1'b1;
        w_load_bit = 1'b1;
        w_next     = S_STOP;
      end
`endif
      S_STOP: if (w_tick) begin
        if (!w_rxd_s) begin
          w_frame_err = 1'b1;
          w_next      = S_WAIT_IDLE;
        end else begin
          w_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
          if ((^r_shift) != r_par) w_par_err   = 1'b1;
          else                     w_byte_done = 1'b1;
`else
          w_byte_done = 1'b1;
`endif
        end
      end
      S_WAIT_IDLE: if (w_rxd_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync     <= '1;
      r_warm     <= '0;
      r_rxd_prev <= 1'b0;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_sync     <= {r_sync[0], uart_rxd_in};
      r_warm     <= {r_warm[0], 1'b1};
      r_rxd_prev <= r_warm[1] & w_rxd_s;

      if (w_load_half)      r_cnt <= CNT_W'(HALF_PERIOD - 1);
      else if (w_load_bit)  r_cnt <= CNT_W'(BIT_PERIOD - 1);
      else if (!w_tick)     r_cnt <= r_cnt - 1'b1;

      if (w_load_half)     r_bit_idx <= '0;
      else if (w_shift_en) r_bit_idx <= r_bit_idx + 1'b1;

      if (w_shift_en) r_shift <= {w_rxd_s, r_shift[7:1]};
`ifdef UART_RX_PARITY_EN
      if (w_par_en) r_par <= w_rxd_s;
`endif

      // A completing byte may load in the same cycle the held one is taken.
      if (w_byte_done && (!r_valid || stream.ready_in)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && stream.ready_in) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign stream.data_out  = r_data;
  assign stream.valid_out = r_valid;
  assign framing_error_out = w_frame_err;
  assign overrun_out       = w_byte_done & r_valid & ~stream.ready_in;
`ifdef UART_RX_PARITY_EN
  assign parity_error_out  = w_par_err;
`else
  assign parity_error_out  = 1'b0;
`endif
endmodule
